// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 matrix keypad one column at a time and synchronises the
//   active-low row inputs. Each press is debounced, encoded to a 4-bit key
//   code, and announced with a single-cycle strobe. Feeds the number-entry
//   FSM: key_code -> num, key_valid -> load_num. Enter = 4'hB, delete = 4'hC.
//
// Parameters
//   SCAN_TICKS       cycles each column stays driven while scanning (>= 4)
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a press
//                    or a release (>= 2)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-low reset
//   row_i      keypad rows, active-low, pulled up, asynchronous to clk
//   col_o      column drive, one-cold (driven column = 0)
//   key_code   code of the last accepted key, held until the next press
//   key_valid  one-cycle strobe, key_code valid in the same cycle
//   key_held   high from key_valid until the release is debounced
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_TICKS      = 1000,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_TICKS > DEBOUNCE_CYCLES) ? SCAN_TICKS : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SCAN_TICKS - 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [1:0]       col_idx;
    logic [1:0]       nxt_col;
    logic [CNT_W-1:0] tick_cnt;
    logic [CNT_W-1:0] nxt_tick;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] nxt_deb;
    logic [3:0]       row_lat;
    logic [3:0]       nxt_row;
    logic             load_code;

    logic [3:0]       row_sync_p0;
    logic [3:0]       row_sync_p1;
    logic [3:0]       row_s;

    // Exactly one row pulled low; zero or several low rows are ambiguous.
    function automatic logic single_low(input logic [3:0] rows);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (!rows[i]) n = n + 3'd1;
        end
        return (n == 3'd1);
    endfunction

    // Keypad legend, rows top to bottom:
    //   1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D   ('*' -> E, '#' -> F)
    function automatic logic [3:0] key_map(input logic [3:0] rows, input logic [1:0] col);
        logic [1:0] r;
        logic [3:0] code;
        case (rows)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            default: r = 2'd3;
        endcase
        code = 4'h0;
        case ({r, col})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'hE;
            4'hD: code = 4'h0;
            4'hE: code = 4'hF;
            4'hF: code = 4'hD;
            default: code = 4'h0;
        endcase
        return code;
    endfunction

    // ---- stage p0/p1: two-flop synchroniser for the asynchronous rows ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_sync_p0 <= 4'hF;
            row_sync_p1 <= 4'hF;
        end else begin
            row_sync_p0 <= row_i;
            row_sync_p1 <= row_sync_p0;
        end
    end

    assign row_s = row_sync_p1;

    // ---- scan / debounce FSM: state and counters ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= SCAN;
            col_idx  <= 2'd0;
            tick_cnt <= '0;
            deb_cnt  <= '0;
            row_lat  <= 4'hF;
            key_code <= 4'h0;
        end else begin
            state    <= nxt_state;
            col_idx  <= nxt_col;
            tick_cnt <= nxt_tick;
            deb_cnt  <= nxt_deb;
            row_lat  <= nxt_row;
            if (load_code) key_code <= key_map(row_lat, col_idx);
        end
    end

    always_comb begin
        nxt_state = state;
        nxt_col   = col_idx;
        nxt_tick  = tick_cnt;
        nxt_deb   = deb_cnt;
        nxt_row   = row_lat;
        load_code = 1'b0;
        case (state)
            SCAN: begin
                if (tick_cnt == TICK_LAST) begin
                    nxt_tick = '0;
                    if (single_low(row_s)) begin
                        // Column stays where it is so the debounce sees the same key.
                        nxt_row   = row_s;
                        nxt_deb   = '0;
                        nxt_state = DEBOUNCE;
                    end else begin
                        nxt_col = col_idx + 2'd1;
                    end
                end else begin
                    nxt_tick = tick_cnt + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s == row_lat) begin
                    if (deb_cnt == DEB_LAST) begin
                        nxt_state = EMIT;
                        load_code = 1'b1;
                    end else begin
                        nxt_deb = deb_cnt + 1'b1;
                    end
                end else begin
                    // Bounce: resume scanning on the same column from tick 0.
                    nxt_state = SCAN;
                    nxt_tick  = '0;
                end
            end
            EMIT: begin
                nxt_deb   = '0;
                nxt_state = RELEASE;
            end
            RELEASE: begin
                // Only an all-high row pattern counts toward the release; any
                // low row (same key or another one on this column) restarts it.
                if (row_s == 4'hF) begin
                    if (deb_cnt == DEB_LAST) begin
                        nxt_state = SCAN;
                        nxt_col   = 2'd0;
                        nxt_tick  = '0;
                        nxt_deb   = '0;
                    end else begin
                        nxt_deb = deb_cnt + 1'b1;
                    end
                end else begin
                    nxt_deb = '0;
                end
            end
            default: nxt_state = SCAN;
        endcase
    end

    assign col_o     = ~(4'b0001 << col_idx);
    assign key_valid = (state == EMIT);
    assign key_held  = (state == EMIT) || (state == RELEASE);

endmodule

// File: tb/tb_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_keypad_scanner
//   Bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_CYCLES=8. A keypad
//   matrix model turns pressed keys plus the driven column into row levels.
//   A behavioural scanner model predicts col_o/key_valid/key_held/key_code
//   every cycle; directed scenarios add hand-computed strobe codes and timings.
// ---------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int ST = 4;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] row_i = 4'hF;
    logic [3:0] col_o;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_CYCLES(DC)) dut (
        .clk      (clk),
        .rst      (rst),
        .row_i    (row_i),
        .col_o    (col_o),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    bit pressed [4][4];
    logic [3:0] strobe_q [$];
    int         strobe_cyc_q [$];

    int kmap [4][4] = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 12}, '{14, 0, 15, 13}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Physical keypad: a row reads low if any pressed key on it sits in a driven column.
    function automatic logic [3:0] keypad_rows(input logic [3:0] cols);
        logic [3:0] r;
        r = 4'hF;
        for (int rr = 0; rr < 4; rr++)
            for (int cc = 0; cc < 4; cc++)
                if (pressed[rr][cc] && !cols[cc]) r[rr] = 1'b0;
        return r;
    endfunction

    initial forever begin
        @(negedge clk);
        #1;
        row_i = keypad_rows(col_o);
    end

    // ---------------- behavioural model ----------------
    int         m_scan_t;   // position within the 4-column scan sweep
    int         m_stable;   // consecutive qualifying cycles
    int         m_row;
    logic [3:0] m_pat;
    logic [3:0] m_s1, m_s2;
    logic [3:0] m_code;
    bit         m_deb, m_emit, m_hold;

    function automatic int zeros(input logic [3:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) n++;
        return n;
    endfunction

    function automatic int low_index(input logic [3:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) idx = i;
        return idx;
    endfunction

    function automatic logic [3:0] exp_col();
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << ((m_scan_t / ST) % 4));
    endfunction

    task automatic model_reset();
        m_scan_t = 0; m_stable = 0; m_row = 0; m_pat = 4'hF;
        m_s1 = 4'hF; m_s2 = 4'hF; m_code = 4'h0;
        m_deb = 0; m_emit = 0; m_hold = 0;
    endtask

    task automatic model_step();
        logic [3:0] rs;
        int col;
        rs = m_s2;
        m_s2 = m_s1;
        m_s1 = row_i;
        col = (m_scan_t / ST) % 4;
        if (m_emit) begin
            m_emit = 0; m_hold = 1; m_stable = 0;
        end else if (m_hold) begin
            if (rs == 4'hF) m_stable++; else m_stable = 0;
            if (m_stable == DC) begin m_hold = 0; m_scan_t = 0; end
        end else if (m_deb) begin
            if (rs == m_pat) begin
                m_stable++;
                if (m_stable == DC) begin
                    m_deb = 0; m_emit = 1; m_code = 4'(kmap[m_row][col]);
                end
            end else begin
                m_deb = 0; m_scan_t = col * ST;
            end
        end else if ((m_scan_t % ST) == ST - 1 && zeros(rs) == 1) begin
            m_deb = 1; m_pat = rs; m_stable = 0; m_row = low_index(rs);
        end else begin
            m_scan_t = (m_scan_t + 1) % (4 * ST);
        end
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the edge.
    initial forever begin
        @(posedge clk);
        if (!rst) begin cyc = 0; model_reset(); end
        else begin cyc++; model_step(); end
        #1;
        check("col_o", 32'(col_o), 32'(exp_col()));
        check("key_valid", 32'(key_valid), 32'(m_emit));
        check("key_held", 32'(key_held), 32'(m_emit | m_hold));
        check("key_code", 32'(key_code), 32'(m_code));
        if (key_valid === 1'b1) begin
            strobe_q.push_back(key_code);
            strobe_cyc_q.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_test();
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
        strobe_q.delete();
        strobe_cyc_q.delete();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic wait_cyc(input int n);
        int g;
        g = 0;
        while (cyc != n && g < 1000) begin @(negedge clk); g++; end
        if (cyc != n) begin
            checks++; errors++;
            $display("FAIL wait_cyc: got %0d expected %0d", cyc, n);
        end
    endtask

    task automatic wait_held(input logic lvl);
        int g;
        g = 0;
        while (key_held !== lvl && g < 200) begin @(negedge clk); g++; end
        check("wait_held", 32'(key_held), 32'(lvl));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int e;

        // 1: idle scan sweep
        start_test();
        rst = 1'b1;
        check("t1_col_c0", 32'(col_o), 32'(4'b1110));
        wait_cyc(4);  check("t1_col_c4", 32'(col_o), 32'(4'b1101));
        wait_cyc(8);  check("t1_col_c8", 32'(col_o), 32'(4'b1011));
        wait_cyc(12); check("t1_col_c12", 32'(col_o), 32'(4'b0111));
        wait_cyc(16); check("t1_col_c16", 32'(col_o), 32'(4'b1110));
        wait_cyc(24); check("t1_nstrobe", 32'(strobe_q.size()), 32'(0));

        // 2: steady '6' (row1/col2): detected at edge 12, strobe at cycle 20
        start_test();
        pressed[1][2] = 1'b1;
        rst = 1'b1;
        wait_cyc(21);
        check("t2_nstrobe", 32'(strobe_q.size()), 32'(1));
        if (strobe_q.size() == 1) begin
            check("t2_code", 32'(strobe_q[0]), 32'(4'h6));
            check("t2_cyc", 32'(strobe_cyc_q[0]), 32'(20));
        end
        check("t2_held", 32'(key_held), 32'(1));
        wait_cyc(30); pressed[1][2] = 1'b0;
        wait_cyc(39); check("t2_held_c39", 32'(key_held), 32'(1));
        wait_cyc(40); check("t2_held_c40", 32'(key_held), 32'(0));
        wait_cyc(60); check("t2_nstrobe_end", 32'(strobe_q.size()), 32'(1));

        // 3: bounce on 'C' (row2/col3) during debounce, then a stable press
        start_test();
        pressed[2][3] = 1'b1;
        rst = 1'b1;
        wait_cyc(17); pressed[2][3] = 1'b0;
        wait_cyc(20); pressed[2][3] = 1'b1;
        wait_cyc(60); pressed[2][3] = 1'b0;
        wait_cyc(90);
        check("t3_nstrobe", 32'(strobe_q.size()), 32'(1));
        if (strobe_q.size() == 1) begin
            check("t3_code", 32'(strobe_q[0]), 32'(4'hC));
            check("t3_cyc", 32'(strobe_cyc_q[0]), 32'(32));
        end

        // 4: two rows low on col1 are rejected; dropping row3 leaves '2'
        start_test();
        pressed[0][1] = 1'b1;
        pressed[3][1] = 1'b1;
        rst = 1'b1;
        wait_cyc(40); check("t4_multi", 32'(strobe_q.size()), 32'(0));
        pressed[3][1] = 1'b0;
        wait_cyc(70);
        check("t4_nstrobe", 32'(strobe_q.size()), 32'(1));
        if (strobe_q.size() == 1) check("t4_code", 32'(strobe_q[0]), 32'(4'h2));
        pressed[0][1] = 1'b0;
        wait_cyc(100); check("t4_nstrobe_end", 32'(strobe_q.size()), 32'(1));

        // 5: '#' held, '5' pressed meanwhile; '5' only after '#' release
        start_test();
        pressed[3][2] = 1'b1;
        rst = 1'b1;
        wait_cyc(25); pressed[1][1] = 1'b1;
        wait_cyc(39);
        check("t5_held", 32'(key_held), 32'(1));
        check("t5_code_hold", 32'(key_code), 32'(4'hF));
        check("t5_n_hold", 32'(strobe_q.size()), 32'(1));
        wait_cyc(40); pressed[3][2] = 1'b0;
        wait_cyc(90);
        check("t5_nstrobe", 32'(strobe_q.size()), 32'(2));
        if (strobe_q.size() == 2) begin
            check("t5_code0", 32'(strobe_q[0]), 32'(4'hF));
            check("t5_code1", 32'(strobe_q[1]), 32'(4'h5));
            check("t5_cyc1", 32'(strobe_cyc_q[1]), 32'(66));
        end
        pressed[1][1] = 1'b0;
        wait_cyc(110);

        // 6: reset during debounce of 'B' (row1/col3); previous code was '1'
        start_test();
        pressed[0][0] = 1'b1;
        rst = 1'b1;
        wait_held(1'b1);
        pressed[0][0] = 1'b0;
        pressed[1][3] = 1'b1;
        wait_held(1'b0);
        e = cyc;
        wait_cyc(e + 19);
        check("t6_code_pre", 32'(key_code), 32'(4'h1));
        rst = 1'b0;
        #1;
        check("t6_rst_valid", 32'(key_valid), 32'(0));
        check("t6_rst_col", 32'(col_o), 32'(4'b1110));
        check("t6_rst_code", 32'(key_code), 32'(4'h0));
        check("t6_rst_held", 32'(key_held), 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        wait_cyc(60); pressed[1][3] = 1'b0;
        wait_cyc(90);
        check("t6_nstrobe", 32'(strobe_q.size()), 32'(2));
        if (strobe_q.size() == 2) begin
            check("t6_code0", 32'(strobe_q[0]), 32'(4'h1));
            check("t6_code1", 32'(strobe_q[1]), 32'(4'hB));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
